// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit, radix-2, one bit per cycle.
// Fixed latency: accept edge k, RUN for 32 cycles, DONE for one cycle, IDLE at k+33.
// Build option MULDIV_DIVIDE_EN: when defined, DIV/DIVU/REM/REMU are implemented.
// When undefined, the divider is removed and a divide request pulses o_illegal instead.
module muldiv_unit #(
  parameter int unsigned Width   = 32,
  parameter int unsigned RegBits = 5
) (
  input  logic               i_clk,
  input  logic               i_res,
  input  logic               i_start,
  input  logic [2:0]         i_funct3,
  input  logic [Width-1:0]   i_rs1_val,
  input  logic [Width-1:0]   i_rs2_val,
  input  logic [RegBits-1:0] i_rd,
  output logic               o_busy,
  output logic [Width-1:0]   o_write,
  output logic [RegBits-1:0] o_write_reg,
  output logic               o_write_enable,
  output logic               o_illegal
);
  localparam int unsigned     CntW    = $clog2(Width);
  localparam logic [CntW-1:0] CntLast = CntW'(Width - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e               r_state;
  logic [CntW-1:0]      r_cnt;
  logic [2:0]           r_op;
  logic [RegBits-1:0]   r_rd;
  logic [Width-1:0]     r_rs1;
  logic [Width-1:0]     r_rs2;
  logic                 r_b_neg;
  logic [2*Width-1:0]   r_acc;
  logic [2*Width-1:0]   r_mcand;
  logic [Width-1:0]     r_mplier;
  logic                 r_busy;
  logic [Width-1:0]     r_write;
  logic [RegBits-1:0]   r_write_reg;
  logic                 r_we;

  logic                 w_accept;
  logic                 w_a_signed;
  logic [2*Width-1:0]   w_acc_nx;
  logic [2*Width-1:0]   w_prod;
  logic [Width-1:0]     w_mul_res;
  logic [Width-1:0]     w_result;

  assign w_accept   = (r_state == StIdle) && i_start;
  // Only MULHU treats rs1 as unsigned; MUL's low word is sign-independent.
  assign w_a_signed = (i_funct3[1:0] != 2'b11);

  // Multiplier step; rs2 is consumed as unsigned, its sign weight corrected at the end
  always_comb begin
    w_acc_nx  = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    w_prod    = w_acc_nx - (r_b_neg ? {r_rs1, {Width{1'b0}}} : '0);
    w_mul_res = (r_op[1:0] == 2'b00) ? w_prod[Width-1:0] : w_prod[2*Width-1:Width];
  end

`ifdef MULDIV_DIVIDE_EN
  logic [Width-1:0] r_rem;
  logic [Width-1:0] r_quo;
  logic [Width-1:0] r_dvsr;
  logic [Width:0]   w_shift;
  logic [Width:0]   w_sub;
  logic             w_fits;
  logic [Width-1:0] w_rem_nx;
  logic [Width-1:0] w_quo_nx;
  logic             w_neg_q;
  logic             w_neg_r;
  logic [Width-1:0] w_div_q;
  logic [Width-1:0] w_div_r;
  logic [Width-1:0] w_mag1;
  logic [Width-1:0] w_mag2;

  assign w_mag1 = (!i_funct3[0] && i_rs1_val[Width-1]) ? -i_rs1_val : i_rs1_val;
  assign w_mag2 = (!i_funct3[0] && i_rs2_val[Width-1]) ? -i_rs2_val : i_rs2_val;

  // Restoring divider step on magnitudes, then sign fix-up and divide-by-zero override
  always_comb begin
    w_shift  = {r_rem, r_quo[Width-1]};
    w_sub    = w_shift - {1'b0, r_dvsr};
    w_fits   = !w_sub[Width];
    w_rem_nx = w_fits ? w_sub[Width-1:0] : w_shift[Width-1:0];
    w_quo_nx = {r_quo[Width-2:0], w_fits};
    w_neg_q  = !r_op[0] && (r_rs1[Width-1] ^ r_rs2[Width-1]);
    w_neg_r  = !r_op[0] && r_rs1[Width-1];
    if (r_rs2 == '0) begin
      w_div_q = '1;
      w_div_r = r_rs1;
    end else begin
      w_div_q = w_neg_q ? -w_quo_nx : w_quo_nx;
      w_div_r = w_neg_r ? -w_rem_nx : w_rem_nx;
    end
    w_result = r_op[2] ? (r_op[1] ? w_div_r : w_div_q) : w_mul_res;
  end

  assign o_illegal = 1'b0;
`else
  logic r_illegal;

  assign w_result  = w_mul_res;
  assign o_illegal = r_illegal;
`endif

  // Control FSM with registered outputs and the shared iteration datapath
  always_ff @(posedge i_clk) begin
    if (!i_res) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_op        <= '0;
      r_rd        <= '0;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_b_neg     <= 1'b0;
      r_acc       <= '0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_busy      <= 1'b0;
      r_write     <= '0;
      r_write_reg <= '0;
      r_we        <= 1'b0;
`ifdef MULDIV_DIVIDE_EN
      r_rem       <= '0;
      r_quo       <= '0;
      r_dvsr      <= '0;
`else
      r_illegal   <= 1'b0;
`endif
    end else begin
      r_we <= 1'b0;
`ifndef MULDIV_DIVIDE_EN
      r_illegal <= 1'b0;
`endif
      case (r_state)
        StIdle: begin
`ifndef MULDIV_DIVIDE_EN
          if (w_accept && i_funct3[2]) begin
            r_illegal <= 1'b1;
          end else
`endif
          if (w_accept) begin
            r_state  <= StRun;
            r_busy   <= 1'b1;
            r_cnt    <= '0;
            r_op     <= i_funct3;
            r_rd     <= i_rd;
            r_rs1    <= i_rs1_val;
            r_rs2    <= i_rs2_val;
            r_b_neg  <= (i_funct3[1:0] == 2'b01) && i_rs2_val[Width-1];
            r_acc    <= '0;
            r_mcand  <= {{Width{w_a_signed & i_rs1_val[Width-1]}}, i_rs1_val};
            r_mplier <= i_rs2_val;
`ifdef MULDIV_DIVIDE_EN
            r_rem    <= '0;
            r_quo    <= w_mag1;
            r_dvsr   <= w_mag2;
`endif
          end
        end
        StRun: begin
          r_acc    <= w_acc_nx;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
`ifdef MULDIV_DIVIDE_EN
          r_rem    <= w_rem_nx;
          r_quo    <= w_quo_nx;
`endif
          r_cnt    <= r_cnt + 1'b1;
          if (r_cnt == CntLast) begin
            r_state     <= StDone;
            r_write     <= w_result;
            r_write_reg <= r_rd;
            r_we        <= (r_rd != '0);
          end
        end
        StDone: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_busy         = r_busy;
  assign o_write        = r_write;
  assign o_write_reg    = r_write_reg;
  assign o_write_enable = r_we;

endmodule
